// File: rtl/branch_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_pkg : ALU op codes, branch funct3 codes, branch FSM state type   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } branch_state_t;

  // 010 and 011 are the only funct3 values not used by conditional branches
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_unit_if : request/response handshakes and ALU control/flags     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface branch_unit_if #(
  parameter int WIDTH = 32
);
  import riscv_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm;

  logic             resp_valid;
  logic             resp_ready;
  logic             taken;
  logic [WIDTH-1:0] target;
  logic             illegal;
  logic             misaligned;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntrl;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             over_flow;

  modport slave (
    input  req_valid, funct3, rs1_val, rs2_val, pc, imm, resp_ready,
           zero, negative, carry, over_flow,
    output req_ready, resp_valid, taken, target, illegal, misaligned,
           alu_a, alu_b, alu_cntrl
  );

  modport master (
    output req_valid, funct3, rs1_val, rs2_val, pc, imm, resp_ready,
    input  req_ready, resp_valid, taken, target, illegal, misaligned
  );

  modport alu (
    input  alu_a, alu_b, alu_cntrl,
    output zero, negative, carry, over_flow
  );

endinterface
`default_nettype wire

// File: rtl/branch_unit_cond.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_cond : maps funct3 and subtract flags to taken / illegal        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       negative_i,
  input  logic       carry_i,
  input  logic       over_flow_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // carry is the no-borrow flag of rs1 - rs2, so it means rs1 >= rs2 unsigned
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = ~is_branch_f3(funct3_i);
    case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = ~zero_i;
      F3_BLT:  taken_o = negative_i ^ over_flow_i;
      F3_BGE:  taken_o = ~(negative_i ^ over_flow_i);
      F3_BLTU: taken_o = ~carry_i;
      F3_BGEU: taken_o = carry_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_unit : multi-cycle conditional branch resolution via shared ALU |
// | Optional: BRANCH_UNIT_ALIGN_CHECK_EN enables the misaligned output     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module branch_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);

  branch_state_t    state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic             misaligned_q, misaligned_d;

  logic             w_taken;
  logic             w_illegal;
  logic             w_misaligned;
  logic             w_req_ready;
  logic             w_resp_valid;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [2:0]       w_alu_cntrl;

  branch_cond u_branch_cond (
    .funct3_i    (funct3_q),
    .zero_i      (bus.zero),
    .negative_i  (bus.negative),
    .carry_i     (bus.carry),
    .over_flow_i (bus.over_flow),
    .taken_o     (w_taken),
    .illegal_o   (w_illegal)
  );

`ifdef BRANCH_UNIT_ALIGN_CHECK_EN
  assign w_misaligned = w_taken & (target_q[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    target_d     = target_q;
    taken_d      = taken_q;
    illegal_d    = illegal_q;
    misaligned_d = misaligned_q;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_alu_a      = '0;
    w_alu_b      = '0;
    w_alu_cntrl  = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          funct3_d = bus.funct3;
          rs1_d    = bus.rs1_val;
          rs2_d    = bus.rs2_val;
          target_d = bus.pc + bus.imm;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        w_alu_a      = rs1_q;
        w_alu_b      = rs2_q;
        w_alu_cntrl  = ALU_SUB;
        taken_d      = w_taken;
        illegal_d    = w_illegal;
        misaligned_d = w_misaligned;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      funct3_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      target_q     <= '0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      target_q     <= target_d;
      taken_q      <= taken_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.taken      = taken_q;
  assign bus.target     = target_q;
  assign bus.illegal    = illegal_q;
  assign bus.misaligned = misaligned_q;
  assign bus.alu_a      = w_alu_a;
  assign bus.alu_b      = w_alu_b;
  assign bus.alu_cntrl  = w_alu_cntrl;

endmodule
`default_nettype wire
